// File: rtl/key_scan_ctrl.sv
`timescale 1ns/1ps
// key_scan_ctrl -- row-scanned key matrix controller with frame debounce.
//
// Drives one matrix row low at a time, samples the (synchronized, inverted)
// columns after SETTLE_CYC cycles, and assembles a whole-matrix frame. A frame
// is accepted once DEB_SCANS identical consecutive frames have been seen; the
// accepted differences against key_state are then reported one key per
// event in ascending index order on a valid/ready interface.
//
// Optional feature: define KEY_SCAN_GHOST_EN to reject ghost frames (two rows
// sharing two or more pressed columns) and report them on ghost_o.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   row_o      row drive, active-low, one row low while scanning
//   col_i      column sense, active-low, asynchronous
//   key_state  debounced level per key (1 = pressed), index row*COLS+col
//   ev_valid   event pending
//   ev_ready   consumer accepts the event
//   ev_key     index of the changed key
//   ev_press   1 = press, 0 = release
//   ghost_o    last COMPARE rejected a ghost frame
module key_scan_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 1000,
  parameter int DEB_SCANS  = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ROWS-1:0]      row_o,
  input  logic [COLS-1:0]      col_i,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [5:0]           ev_key,
  output logic                 ev_press,
  output logic                 ghost_o
);
  localparam int NK = ROWS * COLS;
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW = (NK > 1) ? $clog2(NK) : 1;
  localparam int CW = $clog2(DEB_SCANS);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NK - 1);
  localparam logic [CW-1:0] STB_MAX     = CW'(DEB_SCANS - 1);
  // stable_cnt+1 >= DEB_SCANS-1 rewritten on the pre-increment value
  localparam logic [CW-1:0] STB_EMIT    = CW'(DEB_SCANS - 2);

  typedef enum logic [1:0] {S_DRIVE, S_COMPARE, S_EMIT} state_t;

  state_t          r_state, w_nstate;
  logic            r_started;
  logic [COLS-1:0] r_sync1, r_sync2;
  logic [SW-1:0]   r_cnt;
  logic [RW-1:0]   r_row;
  logic [NK-1:0]   r_raw, r_prev;
  logic [CW-1:0]   r_stable;
  logic [IW-1:0]   r_idx;

  logic [COLS-1:0] w_cols;
  logic            w_same, w_pend, w_diff, w_slot_free, w_step, w_ghost;

  assign w_cols      = ~r_sync2;
  assign w_same      = (r_raw == r_prev);
  assign w_pend      = (r_prev != key_state);
  assign w_diff      = r_prev[r_idx] ^ key_state[r_idx];
  assign w_slot_free = !ev_valid || ev_ready;

  // r_started keeps the rows released during reset; the first cycle after
  // reset is then the first of SETTLE_CYC drive cycles for row 0.
  assign row_o = (r_started && r_state == S_DRIVE) ? ~(ROWS'(1) << r_row) : '1;

`ifdef KEY_SCAN_GHOST_EN
  logic r_ghost;

  always_comb begin : ghost_chk
    logic [COLS-1:0] both;
    w_ghost = 1'b0;
    both    = '0;
    for (int a = 0; a < ROWS; a++) begin
      for (int b = a + 1; b < ROWS; b++) begin
        both = r_raw[a*COLS +: COLS] & r_raw[b*COLS +: COLS];
        // clearing the lowest set bit leaves something => two or more shared
        if ((both & (both - COLS'(1))) != '0) w_ghost = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                   r_ghost <= 1'b0;
    else if (r_state == S_COMPARE) r_ghost <= w_ghost;
  end

  assign ghost_o = r_ghost;
`else
  assign w_ghost = 1'b0;
  assign ghost_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_DRIVE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_step   = 1'b0;
    case (r_state)
      S_DRIVE:
        if (r_started && r_cnt == SETTLE_LAST && r_row == ROW_LAST) w_nstate = S_COMPARE;
      S_COMPARE:
        w_nstate = (!w_ghost && w_same && r_stable >= STB_EMIT && w_pend) ? S_EMIT : S_DRIVE;
      S_EMIT:
        // unchanged keys are skipped even when the slot is busy, so the walk
        // is already parked on the next changed key when the consumer frees it
        if (!w_diff || w_slot_free) begin
          w_step = 1'b1;
          if (r_idx == IDX_LAST) w_nstate = S_DRIVE;
        end
      default: w_nstate = S_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_cnt     <= '0;
      r_row     <= '0;
      r_raw     <= '0;
      r_prev    <= '0;
      r_stable  <= '0;
      r_idx     <= '0;
      key_state <= '0;
      ev_valid  <= 1'b0;
      ev_key    <= '0;
      ev_press  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_sync1   <= col_i;
      r_sync2   <= r_sync1;
      if (ev_valid && ev_ready) ev_valid <= 1'b0;
      case (r_state)
        S_DRIVE: if (r_started) begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt <= '0;
            for (int i = 0; i < ROWS; i++)
              if (r_row == i[RW-1:0]) r_raw[i*COLS +: COLS] <= w_cols;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COMPARE: if (!w_ghost) begin
          if (!w_same) begin
            r_prev   <= r_raw;
            r_stable <= '0;
          end else if (r_stable != STB_MAX) begin
            r_stable <= r_stable + 1'b1;
          end
        end
        S_EMIT: if (w_step) begin
          r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          if (w_diff) begin
            ev_valid         <= 1'b1;
            ev_key           <= 6'(r_idx);
            ev_press         <= r_prev[r_idx];
            key_state[r_idx] <= r_prev[r_idx];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for key_scan_ctrl: 4x4 matrix, SETTLE_CYC=4, DEB_SCANS=3 (17-cycle
// frames). A matrix model turns the pressed-key set into col_i; the expected
// events for a settled change are the keys that differ between the old and
// new pressed sets, in ascending index order, each carrying its new level.
module tb_key_scan_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int FRAME = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_o, col_i;
  logic [15:0] key_state;
  logic        ev_valid, ev_ready, ev_press, ghost_o;
  logic [5:0]  ev_key;

  logic [15:0] keys;
  logic [15:0] model_ks;
  logic [6:0]  obs_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n;

  key_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(4), .DEB_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row_o(row_o), .col_i(col_i),
    .key_state(key_state), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_key(ev_key), .ev_press(ev_press), .ghost_o(ghost_o)
  );

  always #5 clk = ~clk;

  // Columns seen from driven row r. With the ghost feature built in, the
  // matrix has no diodes, so current can sneak through any chain of pressed
  // keys; otherwise each row only sees its own keys.
  function automatic logic [3:0] reach_cols(input logic [15:0] k, input int r);
    logic [3:0] rows, cols;
    rows = 4'b0001 << r;
    cols = '0;
`ifdef KEY_SCAN_GHOST_EN
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4; i++) if (rows[i]) cols |= k[i*4 +: 4];
      for (int i = 0; i < 4; i++) if ((k[i*4 +: 4] & cols) != 4'b0) rows[i] = 1'b1;
    end
`else
    cols = k[r*4 +: 4];
`endif
    return cols;
  endfunction

  always_comb begin
    col_i = '1;
    for (int r = 0; r < 4; r++)
      if (row_o[r] == 1'b0) col_i = col_i & ~reach_cols(keys, r);
  end

  always @(negedge clk)
    if (ev_valid === 1'b1 && ev_ready === 1'b1) obs_q.push_back({ev_press, ev_key});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d n_err=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (ev_valid !== 1'b1 && cyc < budget) begin
      tick(1);
      cyc++;
    end
    chk({tag, "_seen"}, 32'(ev_valid), 1);
  endtask

  // Compare everything the consumer accepted against the old->new diff.
  task automatic cmp_events(input string tag, input logic [15:0] oldk, input logic [15:0] newk);
    logic [6:0] exp_q[$];
    for (int i = 0; i < 16; i++)
      if (oldk[i] != newk[i]) exp_q.push_back({newk[i], 6'(i)});
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_row"},   32'(row_o), 32'hF);
    chk({tag, "_ks"},    32'(key_state), 0);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_key"},   32'(ev_key), 0);
    chk({tag, "_press"}, 32'(ev_press), 0);
    chk({tag, "_ghost"}, 32'(ghost_o), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ev_ready = 1'b1;
    keys     = '0;
    model_ks = '0;

    // reset, then row 0 for four cycles followed by row 1
    tick(2);
    chk_reset("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      chk("row0_drive", 32'(row_o), 32'hE);
    end
    tick(1);
    chk("row1_drive", 32'(row_o), 32'hD);

    // single press of key 6 (row 1, col 2)
    keys = 16'h0040;
    wait_valid("press", 120, n);
    chk("press_key", 32'(ev_key), 6);
    chk("press_dir", 32'(ev_press), 1);
    chk("press_latency_in_window", 32'(n >= 30 && n <= 90), 1);
    tick(5 * FRAME);
    cmp_events("press", 16'h0000, 16'h0040);
    chk("press_state", 32'(key_state), 32'h0040);
    model_ks = 16'h0040;

    keys = 16'h0000;
    tick(6 * FRAME);
    cmp_events("release6", model_ks, keys);
    model_ks = keys;

    // bounce: one toggle per frame length, so every frame samples the
    // opposite level and no run of identical frames can form
    for (int t = 0; t < 5; t++) begin
      keys[6] = ~keys[6];
      tick(FRAME);
    end
    keys[6] = 1'b0;
    tick(6 * FRAME);
    cmp_events("bounce", model_ks, keys);
    chk("bounce_state", 32'(key_state), 0);
    keys[6] = 1'b1;
    tick(7 * FRAME);
    cmp_events("bounce_hold", model_ks, keys);
    model_ks = keys;

    // keys 3 and 12 with the consumer stalled
    ev_ready = 1'b0;
    keys     = 16'h1048;
    wait_valid("multi", 150, n);
    chk("multi_first_key", 32'(ev_key), 3);
    chk("multi_first_dir", 32'(ev_press), 1);
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk("stall_valid", 32'(ev_valid), 1);
      chk("stall_key",   32'(ev_key), 3);
      chk("stall_row",   32'(row_o), 32'hF);
    end
    ev_ready = 1'b1;
    tick(1);
    chk("b2b_valid", 32'(ev_valid), 1);
    chk("b2b_key",   32'(ev_key), 12);
    chk("b2b_dir",   32'(ev_press), 1);
    tick(1);
    chk("b2b_drained", 32'(ev_valid), 0);
    tick(2 * FRAME);
    cmp_events("multi", model_ks, keys);
    chk("multi_state", 32'(key_state), 32'h1048);
    model_ks = keys;

    // release everything: ascending order 3, 6, 12
    keys = 16'h0000;
    tick(7 * FRAME);
    cmp_events("release_all", model_ks, keys);
    chk("release_state", 32'(key_state), 0);
    model_ks = keys;

    // reset while an event is held
    ev_ready = 1'b0;
    keys     = 16'h1008;
    wait_valid("rst_emit", 150, n);
    chk("rst_emit_key", 32'(ev_key), 3);
    rst_n = 1'b0;
    keys  = 16'h0000;
    tick(2);
    chk_reset("midreset");
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    tick(6 * FRAME);
    cmp_events("post_reset", 16'h0000, 16'h0000);
    chk("post_reset_state", 32'(key_state), 0);
    model_ks = '0;

`ifdef KEY_SCAN_GHOST_EN
    // keys 0,1,4 make key 5 appear: rows 0 and 1 share columns 0 and 1
    keys = 16'h0013;
    tick(6 * FRAME);
    chk("ghost_flag", 32'(ghost_o), 1);
    cmp_events("ghost", 16'h0000, 16'h0000);
    chk("ghost_state", 32'(key_state), 0);
    keys = 16'h0003;
    tick(6 * FRAME);
    chk("ghost_clear", 32'(ghost_o), 0);
    cmp_events("ghost_release", 16'h0000, 16'h0003);
    model_ks = 16'h0003;
`endif

    // random pressed sets with a randomly stalling consumer
    for (int p = 0; p < 8; p++) begin
      logic [15:0] nk;
`ifdef KEY_SCAN_GHOST_EN
      // at most one key per column keeps the frame ghost-free
      nk = '0;
      for (int c = 0; c < 4; c++) begin
        int r;
        r = int'($urandom_range(0, 4));
        if (r < 4) nk[r*4 + c] = 1'b1;
      end
`else
      nk = 16'($urandom);
`endif
      keys = nk;
      for (int c = 0; c < 170; c++) begin
        ev_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
      ev_ready = 1'b1;
      tick(40);
      cmp_events("random", model_ks, nk);
      chk("random_state", 32'(key_state), 32'(nk));
      model_ks = nk;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
